// File: rtl/som_train_ctrl.sv
// som_train_ctrl: sequencing controller for self-organising-map training.
// It walks EPOCHS x SAMPLES input vectors through the sequence
// fetch -> distance -> winner latch -> neighbourhood update.
// The neighbourhood radius and the learning-rate shift decay once per epoch.
// Optional macro WSC_SETTLE_EN inserts one SETTLE cycle between DIST and
// LATCH, so the winner compare tree settles before win_x/win_y are captured.
module som_train_ctrl #(
  parameter int         SAMPLES = 64,
  parameter int         EPOCHS  = 8,
  parameter logic [2:0] R_INIT  = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vec_valid,
  output logic       vec_ready,
  output logic       dist_start,
  input  logic       dist_done,
  input  logic [2:0] winner_x,
  input  logic [2:0] winner_y,
  output logic       upd_en,
  input  logic       upd_done,
  output logic [2:0] win_x,
  output logic [2:0] win_y,
  output logic [2:0] upd_radius,
  output logic [2:0] upd_shift,
  output logic       busy,
  output logic       done,
  output logic [7:0] epoch,
  output logic [9:0] sample
);

  localparam logic [9:0] SAMPLE_LAST = 10'(SAMPLES - 1);
  localparam logic [7:0] EPOCH_LAST  = 8'(EPOCHS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DIST,
    S_LATCH,
    S_UPDATE,
    S_NEXT
`ifdef WSC_SETTLE_EN
    , S_SETTLE
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] epoch_q, epoch_d;
  logic [9:0] sample_q, sample_d;
  logic [2:0] radius_q, radius_d;
  logic [2:0] shift_q, shift_d;
  logic [2:0] win_x_q, win_x_d;
  logic [2:0] win_y_q, win_y_d;
  logic       dist_start_q, dist_start_d;
  logic       upd_en_q, upd_en_d;
  logic       done_c;

  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  function automatic logic [2:0] inc_sat(input logic [2:0] v);
    return (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

  // Next-state, counter/decay update and pulse generation.
  // dist_start_q / upd_en_q are high only in the first DIST / UPDATE cycle;
  // they also mask a done strobe that coincides with their own pulse.
  always_comb begin
    state_d      = state_q;
    epoch_d      = epoch_q;
    sample_d     = sample_q;
    radius_d     = radius_q;
    shift_d      = shift_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    dist_start_d = 1'b0;
    upd_en_d     = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          epoch_d  = 8'd0;
          sample_d = 10'd0;
          shift_d  = 3'd0;
          radius_d = R_INIT;
        end
      end
      S_FETCH: begin
        if (vec_valid) begin
          state_d      = S_DIST;
          dist_start_d = 1'b1;
        end
      end
      S_DIST: begin
        if (dist_done && !dist_start_q) begin
`ifdef WSC_SETTLE_EN
          state_d = S_SETTLE;
`else
          state_d = S_LATCH;
`endif
        end
      end
`ifdef WSC_SETTLE_EN
      S_SETTLE: state_d = S_LATCH;
`endif
      S_LATCH: begin
        win_x_d  = winner_x;
        win_y_d  = winner_y;
        upd_en_d = 1'b1;
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        if (upd_done && !upd_en_q) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (sample_q != SAMPLE_LAST) begin
          sample_d = sample_q + 10'd1;
          state_d  = S_FETCH;
        end else if (epoch_q != EPOCH_LAST) begin
          sample_d = 10'd0;
          epoch_d  = epoch_q + 8'd1;
          radius_d = dec_sat(radius_q);
          shift_d  = inc_sat(shift_q);
          state_d  = S_FETCH;
        end else begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, abandoning any sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      epoch_q      <= 8'd0;
      sample_q     <= 10'd0;
      radius_q     <= 3'd0;
      shift_q      <= 3'd0;
      win_x_q      <= 3'd0;
      win_y_q      <= 3'd0;
      dist_start_q <= 1'b0;
      upd_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      epoch_q      <= epoch_d;
      sample_q     <= sample_d;
      radius_q     <= radius_d;
      shift_q      <= shift_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      dist_start_q <= dist_start_d;
      upd_en_q     <= upd_en_d;
    end
  end

  assign vec_ready  = (state_q == S_FETCH);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_c;
  assign dist_start = dist_start_q;
  assign upd_en     = upd_en_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign upd_radius = radius_q;
  assign upd_shift  = shift_q;
  assign epoch      = epoch_q;
  assign sample     = sample_q;

endmodule

// File: doc/som_train_ctrl.md
SOM_TRAIN_CTRL -- requirements
Module: som_train_ctrl

Interface
REQ-001 SHALL have parameter SAMPLES, default 64, meaning training vectors per epoch (1..1024).
REQ-002 SHALL have parameter EPOCHS, default 8, meaning epochs per training run (1..255).
REQ-003 SHALL have parameter R_INIT, default 3'd7, meaning the neighbourhood radius in epoch 0.
REQ-004 SHALL have one clock; reset is synchronous and active-low; ports are named clk and rst_n.
REQ-005 SHALL have the following ports, listed as name, direction, width and meaning:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a training run; sampled only in IDLE
- vec_valid  in  1  an input vector is available
- vec_ready  out  1  controller accepts the vector this cycle
- dist_start  out  1  one-cycle pulse telling the 64 VEPs to compute Manhattan distances
- dist_done  in  1  all VEP distances are stable
- winner_x, winner_y  in  3 each  combinational winner coordinates from the winner search circuit
- upd_en  out  1  one-cycle pulse starting the neighbourhood weight update
- upd_done  in  1  weight update finished
- win_x, win_y  out  3 each  latched winner coordinates
- upd_radius  out  3  current neighbourhood radius
- upd_shift  out  3  learning-rate shift (alpha = 2^-upd_shift)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the run completes
- epoch  out  8  current epoch index
- sample  out  10  current sample index

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, DIST, LATCH, UPDATE and NEXT, plus SETTLE when WSC_SETTLE_EN is defined.
REQ-007 IDLE: start=1 -> FETCH; epoch, sample and upd_shift SHALL be cleared and upd_radius loaded with R_INIT; start in any other state SHALL be ignored.
REQ-008 FETCH: vec_ready=1; on vec_valid&&vec_ready, the FSM SHALL go to DIST and assert dist_start for exactly the first DIST cycle.
REQ-009 DIST: the FSM SHALL wait for dist_done, then go to LATCH (or SETTLE); a dist_done arriving in the same cycle as dist_start SHALL be ignored.
REQ-010 LATCH: the FSM SHALL register win_x<=winner_x and win_y<=winner_y, then go to UPDATE and assert upd_en for exactly one cycle (the first UPDATE cycle).
REQ-011 UPDATE: the FSM SHALL wait for upd_done; upd_done in the upd_en cycle SHALL be ignored; on upd_done -> NEXT.
REQ-012 NEXT, sample<SAMPLES-1: sample SHALL increment and the FSM SHALL go to FETCH.
REQ-013 NEXT, sample==SAMPLES-1 and epoch<EPOCHS-1: sample<=0 and epoch SHALL increment; upd_radius SHALL decrement, saturating at 0; upd_shift SHALL increment, saturating at 7; -> FETCH.
REQ-014 NEXT, last sample of the last epoch: done SHALL pulse for one cycle and the FSM SHALL go to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 win_x and win_y SHALL hold their values until the next LATCH, including after done.
REQ-017 Latency from vec accept to upd_en SHALL be 2 + Tdist cycles without WSC_SETTLE_EN and 3 + Tdist with it, where Tdist is the number of DIST cycles.

Reset
REQ-018 rst_n=0 at a clock edge SHALL force IDLE and clear busy, done, vec_ready, dist_start, upd_en, win_x, win_y, epoch, sample, upd_radius and upd_shift to 0, regardless of current state.
REQ-019 A reset during DIST or UPDATE SHALL abandon the sample; no upd_en or done SHALL follow it.

Configuration
REQ-020 Macro WSC_SETTLE_EN defined: one SETTLE cycle SHALL be inserted between DIST and LATCH so the 6-level compare tree settles before capture.
REQ-021 WSC_SETTLE_EN undefined: DIST SHALL go directly to LATCH on dist_done.

Verification
REQ-022 Basic run: SAMPLES=2, EPOCHS=1, vec_valid held high, dist_done and upd_done each 2 cycles after their pulse -> 2 upd_en pulses, one done pulse, then busy=0.
REQ-023 Winner capture: winner_x=5 and winner_y=3 during LATCH -> win_x=5 and win_y=3 thereafter; later changes on winner_x/winner_y do not alter them until the next LATCH.
REQ-024 Decay: R_INIT=7, EPOCHS=10, SAMPLES=1 -> upd_radius steps 7,6,...,0,0 across epochs and upd_shift saturates at 7.
REQ-025 Backpressure: vec_valid low for 5 cycles in FETCH -> vec_ready stays 1, no dist_start is issued, and the counters are unchanged.
REQ-026 Reset mid-UPDATE: rst_n=0 for 1 cycle -> all outputs read 0 the next cycle; a late upd_done is ignored; no done pulse.
REQ-027 Macro check: the same stimulus with and without WSC_SETTLE_EN -> upd_en occurs exactly 1 cycle later when the macro is defined.
